// File: rtl/ks_sub_pipe.sv
// ks_sub_pipe: pipelined 32-bit Kogge-Stone add/subtract unit with a valid/ready handshake.
// Define KS_SUB_FLAGS_EN to add the registered o_zero / o_neg result flags.
module ks_sub_pipe #(
  parameter int         WIDTH      = 32,
  parameter int         TAG_W      = 4,
  parameter logic [4:0] STAGE_MASK = 5'b11111
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic [TAG_W-1:0] o_tag
`ifdef KS_SUB_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_neg
`endif
);

  localparam int LEVELS = 5;

  // gg/gp are the running group generate/propagate; p is the untouched bitwise propagate.
  typedef struct packed {
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] p;
    logic             c0;
    logic             a31;
    logic             b31;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } stage_t;

  // One Kogge-Stone level; the first level folds c0 into bit 0 as the G[-1] neighbour.
  function automatic stage_t ks_level(input stage_t s, input int span, input bit first);
    stage_t           r;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    int               j;
    g_in = s.gg;
    p_in = s.gp;
    if (first) begin
      g_in[0] = s.gg[0] | (s.gp[0] & s.c0);
      p_in[0] = 1'b0;
    end
    r = s;
    for (int i = 0; i < WIDTH; i++) begin
      j = (i >= span) ? (i - span) : 0;
      if (i >= span) begin
        r.gg[i] = g_in[i] | (p_in[i] & g_in[j]);
        r.gp[i] = p_in[i] & p_in[j];
      end else begin
        r.gg[i] = g_in[i];
        r.gp[i] = p_in[i];
      end
    end
    return r;
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_x;
  stage_t           pg_q;
  stage_t           lvl_d [LEVELS];
  stage_t           lvl_q [LEVELS];
  stage_t           fin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // A single stall enable freezes every stage, bubbles included.
  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign b_x     = i_b ^ {WIDTH{i_sub}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pg_q <= '0;
    end else if (en) begin
      pg_q.valid <= i_valid;
      if (i_valid) begin
        pg_q.gg  <= i_a & b_x;
        pg_q.gp  <= i_a ^ b_x;
        pg_q.p   <= i_a ^ b_x;
        pg_q.c0  <= i_sub;
        pg_q.a31 <= i_a[WIDTH-1];
        pg_q.b31 <= b_x[WIDTH-1];
        pg_q.tag <= i_tag;
      end
    end
  end

  // Walk the prefix levels; STAGE_MASK picks whether each level's result comes from a register.
  always_comb begin
    fin = pg_q;
    for (int k = 0; k < LEVELS; k++) begin
      lvl_d[k] = ks_level(fin, 1 << k, k == 0);
      fin      = STAGE_MASK[k] ? lvl_q[k] : lvl_d[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < LEVELS; k++) begin
        lvl_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < LEVELS; k++) begin
        if (STAGE_MASK[k]) begin
          lvl_q[k] <= lvl_d[k];
        end
      end
    end
  end

  assign sum_d  = fin.p ^ {fin.gg[WIDTH-2:0], fin.c0};
  assign cout_d = fin.gg[WIDTH-1];
  assign ovf_d  = (fin.a31 == fin.b31) && (sum_d[WIDTH-1] != fin.a31);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
      o_tag   <= '0;
`ifdef KS_SUB_FLAGS_EN
      o_zero  <= 1'b0;
      o_neg   <= 1'b0;
`endif
    end else if (en) begin
      o_valid <= fin.valid;
      o_sum   <= sum_d;
      o_cout  <= cout_d;
      o_ovf   <= ovf_d;
      o_tag   <= fin.tag;
`ifdef KS_SUB_FLAGS_EN
      o_zero  <= (sum_d == '0);
      o_neg   <= sum_d[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_ks_sub_pipe.sv
// tb_ks_sub_pipe: directed self-checking bench for ks_sub_pipe (default STAGE_MASK, latency 7).
// Flag checks are compiled in when KS_SUB_FLAGS_EN is defined.
module tb_ks_sub_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_sub;
  logic [3:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_cout;
  logic        o_ovf;
  logic [3:0]  o_tag;
`ifdef KS_SUB_FLAGS_EN
  logic        o_zero;
  logic        o_neg;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  ks_sub_pipe dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_sub   (i_sub),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_tag   (o_tag)
`ifdef KS_SUB_FLAGS_EN
    ,
    .o_zero  (o_zero),
    .o_neg   (o_neg)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic [3:0] tag, input logic valid);
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_tag   = tag;
    i_valid = valid;
  endtask

  // Reference result packed as {tag, ovf, cout, sum}, using a plain 33-bit add.
  function automatic logic [37:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic [3:0] tag);
    logic [31:0] bx;
    logic [32:0] ext;
    logic        ovf;
    bx  = b ^ {32{sub}};
    ext = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
    ovf = (a[31] == bx[31]) && (ext[31] != a[31]);
    return {tag, ovf, ext[32], ext[31:0]};
  endfunction

  function automatic logic [31:0] opA(input int j);
    return 32'h0123_4567 * 32'(j + 1);
  endfunction

  function automatic logic [31:0] opB(input int j);
    return 32'h89AB_CDEF ^ (32'(j) * 32'h1357_9BDF);
  endfunction

  // Single operation: check latency from accept and the full result.
  task automatic runSingle(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [3:0] tag, input logic [31:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
    int lat;
    i_ready = 1'b1;
    applyStimulus(a, b, sub, tag, 1'b1);
    #1;
    checkOutput({name, "_ready"}, 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;
    applyStimulus('0, '0, 1'b0, 4'd0, 1'b0);
    lat = 1;
    while (!o_valid && lat < 30) begin
      @(posedge i_clk); #1;
      lat++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'd7);
    checkOutput({name, "_sum"},  64'(o_sum),  64'(exp_sum));
    checkOutput({name, "_cout"}, 64'(o_cout), 64'(exp_cout));
    checkOutput({name, "_ovf"},  64'(o_ovf),  64'(exp_ovf));
    checkOutput({name, "_tag"},  64'(o_tag),  64'(tag));
`ifdef KS_SUB_FLAGS_EN
    checkOutput({name, "_zero"}, 64'(o_zero), 64'(exp_sum == 32'd0));
    checkOutput({name, "_neg"},  64'(o_neg),  64'(exp_sum[31]));
`endif
    @(posedge i_clk); #1;
  endtask

  // Continuous issue with optional consumer stall; results checked in order against a queue.
  task automatic runStream(input string name, input int n_ops, input int stall_at, input int stall_len,
                           output int delivered, output int first_cyc, output int last_cyc);
    logic [37:0] exp_q[$];
    logic [37:0] front;
    int          issued;
    int          cyc;
    issued    = 0;
    cyc       = 0;
    delivered = 0;
    first_cyc = -1;
    last_cyc  = -1;
    while ((issued < n_ops || exp_q.size() > 0) && cyc < 200) begin
      i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (issued < n_ops) begin
        applyStimulus(opA(issued), opB(issued), issued[0], issued[3:0], 1'b1);
      end else begin
        applyStimulus('0, '0, 1'b0, 4'd0, 1'b0);
      end
      #1;
      if (!i_ready && o_valid) begin
        checkOutput({name, "_stall_ready"}, 64'(o_ready), 64'd0);
        if (exp_q.size() > 0) begin
          checkOutput({name, "_stall_hold"}, 64'({o_tag, o_ovf, o_cout, o_sum}), 64'(exp_q[0]));
        end
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() > 0) begin
          front = exp_q.pop_front();
          checkOutput({name, "_result"}, 64'({o_tag, o_ovf, o_cout, o_sum}), 64'(front));
        end
        delivered++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_a, i_b, i_sub, i_tag));
        issued++;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    applyStimulus('0, '0, 1'b0, 4'd0, 1'b0);
    i_ready = 1'b1;
    checkOutput({name, "_count"}, 64'(delivered), 64'(n_ops));
  endtask

  initial begin
    int delivered;
    int first_cyc;
    int last_cyc;
    int seen;

    i_rst   = 1'b1;
    i_ready = 1'b1;
    applyStimulus('0, '0, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_ready", 64'(o_ready), 64'd1);
    checkOutput("rst_sum",   64'(o_sum),   64'd0);
    checkOutput("rst_cout",  64'(o_cout),  64'd0);
    checkOutput("rst_ovf",   64'(o_ovf),   64'd0);
    checkOutput("rst_tag",   64'(o_tag),   64'd0);

    runSingle("sub_5_3",   32'd5,          32'd3, 1'b1, 4'd1, 32'd2,          1'b1, 1'b0);
    runSingle("sub_3_5",   32'd3,          32'd5, 1'b1, 4'd2, 32'hFFFF_FFFE,  1'b0, 1'b0);
    runSingle("add_ovf",   32'h7FFF_FFFF,  32'd1, 1'b0, 4'd3, 32'h8000_0000,  1'b0, 1'b1);
    runSingle("sub_ovf",   32'h8000_0000,  32'd1, 1'b1, 4'd4, 32'h7FFF_FFFF,  1'b1, 1'b1);
    runSingle("add_wrap",  32'hFFFF_FFFF,  32'd1, 1'b0, 4'd5, 32'd0,          1'b1, 1'b0);
    runSingle("add_mixed", 32'h1234_5678,  32'h0F0F_0F0F, 1'b0, 4'd6, 32'h2143_6587, 1'b0, 1'b0);

    runStream("b2b", 20, 1000, 0, delivered, first_cyc, last_cyc);
    checkOutput("b2b_first", 64'(first_cyc), 64'd7);
    checkOutput("b2b_span",  64'(last_cyc - first_cyc + 1), 64'd20);

    runStream("stall", 16, 10, 5, delivered, first_cyc, last_cyc);

    // Four operations in flight, then a one-cycle reset must discard all of them.
    for (int j = 0; j < 4; j++) begin
      applyStimulus(32'hAAAA_0000 + 32'(j), 32'd1, 1'b0, 4'(9 + j), 1'b1);
      @(posedge i_clk); #1;
    end
    applyStimulus('0, '0, 1'b0, 4'd0, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checkOutput("flush_valid", 64'(o_valid), 64'd0);
    checkOutput("flush_sum",   64'(o_sum),   64'd0);
    checkOutput("flush_ready", 64'(o_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid) seen++;
      @(posedge i_clk); #1;
    end
    checkOutput("flush_none", 64'(seen), 64'd0);
    runSingle("after_rst", 32'd0, 32'd0, 1'b1, 4'd7, 32'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
